// File: rtl/interp_pkg.sv
// interp_pkg: shared defaults and elaboration/saturation helpers for the interpolator
package interp_pkg;
    localparam int W_DEF = 20;
    localparam int RATIO_DEF = 50;
    localparam int FRAC_DEF = 12;
    localparam int SH_DEF = 16;

    function automatic int recip(input int sh, input int ratio);
        return ((1 << sh) + ratio / 2) / ratio;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return x > hi ? hi : x < lo ? lo : x;
    endfunction
endpackage

// File: rtl/interp_step.sv
// interp_step: per-clock increment (v - v_prev) / RATIO using a fixed-point reciprocal
module interp_step #(
    parameter int AW = 34,
    parameter int SH = 16,
    parameter int RECIP = 1311
) (
    input  logic signed [AW-1:0] v,
    input  logic signed [AW-1:0] v_prev,
    output logic signed [AW-1:0] step
);
    localparam int PW = AW + SH + 2;

    logic signed [PW-1:0] diff;
    logic signed [PW-1:0] prod;

    assign diff = PW'(v) - PW'(v_prev);
    assign prod = diff * PW'(RECIP);
    assign step = AW'(prod >>> SH);
endmodule

// File: rtl/lin_interp.sv
// lin_interp: upsamples one input sample every RATIO clocks by linear ramp or zero-order hold
module lin_interp
    import interp_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int RATIO = RATIO_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int SH = SH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         mode,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    output logic [W-1:0] y,
    output logic         underrun,
    input  logic         clr_underrun
);
    localparam int AW = W + FRAC + 2;
    localparam int PH_W = $clog2(RATIO);
    localparam int RECIP = recip(SH, RATIO);

    logic [PH_W-1:0] ph;
    logic signed [AW-1:0] v;
    logic signed [AW-1:0] v_prev;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] step;
    logic mode_q;
    logic boundary;

    assign boundary = ph == PH_W'(RATIO - 1);
    assign s_ready = boundary && !reset;
    assign y = reset ? '0 : W'(saturate(64'(acc >>> FRAC), W));

    interp_step #(.AW(AW), .SH(SH), .RECIP(RECIP)) u_step (
        .v(v),
        .v_prev(v_prev),
        .step(step)
    );

    // phase counter, sample pair, accumulator and sticky underrun; segment restarts at each boundary
    always_ff @(posedge clock) begin
        if (reset) begin
            ph <= '0;
            v <= '0;
            v_prev <= '0;
            acc <= '0;
            mode_q <= 1'b0;
            underrun <= 1'b0;
        end else begin
            ph <= boundary ? '0 : ph + 1'b1;
            underrun <= clr_underrun ? 1'b0 : (boundary && !s_valid) ? 1'b1 : underrun;
            if (boundary) begin
                v_prev <= v;
                if (s_valid)
                    v <= AW'($signed(s_data)) <<< FRAC;
                acc <= v;
                mode_q <= mode;
            end else if (!mode_q) begin
                acc <= acc + step;
            end
        end
    end
endmodule

// File: tb/tb_lin_interp.sv
// tb_lin_interp: directed vectors for ramp, hold, underrun, saturation and mid-run reset
module tb_lin_interp;
    localparam int W = 20;
    localparam int RATIO = 50;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mode = 1'b0;
    logic s_valid = 1'b0;
    logic signed [W-1:0] s_data = '0;
    logic s_ready;
    logic signed [W-1:0] y;
    logic underrun;
    logic clr_underrun = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int prev;
    int d;
    int n;

    lin_interp dut (
        .clock(clock),
        .reset(reset),
        .mode(mode),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .y(y),
        .underrun(underrun),
        .clr_underrun(clr_underrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!s_ready && k < RATIO + 5) begin
            @(negedge clock);
            k++;
        end
        chk("ready", 64'(s_ready), 1);
    endtask

    task automatic push(input logic signed [W-1:0] v);
        wait_ready();
        s_data = v;
        s_valid = 1'b1;
        @(negedge clock);
        s_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_y", y, 0);
        chk("rst_rdy", 64'(s_ready), 0);
        chk("rst_ur", 64'(underrun), 0);
        reset = 1'b0;
        n = 1;
        while (!s_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("rdy_lat", n, 50);
        push(0);
        push(1000);
        chk("ramp0", y, 0);
        for (int k = 1; k < RATIO; k++) begin
            @(negedge clock);
            chk("ramp", y, 20 * k);
        end
        chk("ramp_rdy", 64'(s_ready), 1);
        push(-1000);
        chk("ramp_end", y, 1000);
        prev = 1000;
        for (int k = 1; k < RATIO; k++) begin
            @(negedge clock);
            d = prev - int'(y);
            chk("neg_step", 64'(d >= 40 && d <= 41), 1);
            prev = int'(y);
        end
        mode = 1'b1;
        push(5);
        chk("neg_end", y, -1000);
        for (int k = 1; k < RATIO; k++) begin
            @(negedge clock);
            chk("hold_old", y, -1000);
        end
        push(7);
        chk("hold5", y, 5);
        for (int k = 1; k < RATIO; k++) begin
            @(negedge clock);
            if (k == 20)
                mode = 1'b0;
            chk("hold5", y, 5);
        end
        push(107);
        chk("hold7", y, 7);
        @(negedge clock);
        chk("lin_resume", y, 9);
        wait_ready();
        @(negedge clock);
        chk("ur_set", 64'(underrun), 1);
        chk("ur_flat", y, 107);
        for (int k = 1; k < RATIO; k++) begin
            @(negedge clock);
            clr_underrun = (k == 10);
            chk("ur_flat", y, 107);
            if (k == 11)
                chk("ur_clr", 64'(underrun), 0);
        end
        chk("ur_rdy", 64'(s_ready), 1);
        clr_underrun = 1'b1;
        @(negedge clock);
        clr_underrun = 1'b0;
        chk("ur_simul", 64'(underrun), 0);
        push(524287);
        push(-524288);
        chk("sat_hi", y, 524287);
        prev = int'(y);
        for (int k = 1; k < RATIO; k++) begin
            @(negedge clock);
            chk("sat_dn", 64'(int'(y) < prev), 1);
            prev = int'(y);
        end
        push(524287);
        chk("sat_lo", y, -524288);
        prev = int'(y);
        for (int k = 1; k < RATIO; k++) begin
            @(negedge clock);
            chk("sat_up", 64'(int'(y) > prev), 1);
            prev = int'(y);
        end
        push(0);
        chk("sat_hi2", y, 524287);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mr_y", y, 0);
        chk("mr_rdy", 64'(s_ready), 0);
        reset = 1'b0;
        n = 1;
        while (!s_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("mr_lat", n, 50);
        chk("mr_y0", y, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
